// File: rtl/cpu_handshake_sender.sv
// CPU-side 4-phase send/ack initiator with a small write FIFO.
// Optional REQ timeout abort: define CPU_SENDER_TIMEOUT_EN.
module cpu_handshake_sender #(
  parameter int DATA_W         = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              send,
  output logic [DATA_W-1:0] data,
  input  logic              ack,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count,
  output logic              timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty;

  // Storage array; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CPU_SENDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;
  logic          aborted;
  logic          to_err;

  assign timeout_err = to_err;

  // Handshake FSM with REQ timeout; an aborted word is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      send       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      sent_count <= '0;
      tcnt       <= '0;
      aborted    <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            data    <= mem[rd_ptr];
            send    <= 1'b1;
            busy    <= 1'b1;
            tcnt    <= '0;
            aborted <= 1'b0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            send  <= 1'b0;
            state <= REL;
          end else if (tcnt == TLAST) begin
            send    <= 1'b0;
            to_err  <= 1'b1;
            aborted <= 1'b1;
            state   <= REL;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        REL: begin
          if (!ack) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (!aborted) sent_count <= sent_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // No counter is built; the timeout depth only matters when it is.
  assign timeout_err = (TIMEOUT_CYCLES < 0);

  // Handshake FSM: REQ waits for ack indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      send       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            data  <= mem[rd_ptr];
            send  <= 1'b1;
            busy  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            send  <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          if (!ack) begin
            busy       <= 1'b0;
            sent_count <= sent_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
